// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the elastic pipeline_register slice.
// Both the top and the per-stage register module import this package.
package pipeline_pkg;

  localparam int XFER_COUNT_W = 32;

  // Width needed to count 0..stages valid entries.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipeline_stage.sv
// One valid/data register pair of the elastic pipeline.
// A load takes priority over a clear; reset beats both.
module pipeline_stage
  import pipeline_pkg::*;
#(
  parameter int             N           = 1,
  parameter logic [N-1:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [N-1:0] i_data,
  output logic         o_valid,
  output logic [N-1:0] o_data
);

  logic         r_valid;
  logic [N-1:0] r_data;

  // Data only moves on a load, so a clear (drain or flush) leaves it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VALUE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipeline_register.sv
// Elastic STAGES-deep valid/ready pipeline with bubble collapsing, flush and enable.
// Define PIPELINE_REGISTER_COUNT_EN to add the 32-bit xfer_count output-transfer counter.
module pipeline_register
  import pipeline_pkg::*;
#(
  parameter int           N           = 1,
  parameter int           STAGES      = 2,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0]                  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0]                  out_data,
  output logic [occ_width(STAGES)-1:0]  occupancy
`ifdef PIPELINE_REGISTER_COUNT_EN
  ,
  output logic [XFER_COUNT_W-1:0]       xfer_count
`endif
);

  localparam int OCC_W = occ_width(STAGES);

  logic              w_go;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_ready;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_leave;
  logic [STAGES-1:0] w_clear;
  logic [N-1:0]      w_data    [STAGES];
  logic [N-1:0]      w_stageIn [STAGES];

  assign w_go = ena & ~flush;

  // A stage can take an item if it is empty or its own item moves on this cycle.
  always_comb begin
    w_ready = '0;
    w_ready[STAGES-1] = ~w_valid[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_ready[i] = ~w_valid[i] | w_ready[i+1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : gStage
    if (g == 0) begin : gHead
      assign w_load[g]    = w_go & in_valid & w_ready[g];
      assign w_stageIn[g] = in_data;
    end else begin : gBody
      assign w_load[g]    = w_go & w_valid[g-1] & w_ready[g];
      assign w_stageIn[g] = w_data[g-1];
    end

    if (g == STAGES - 1) begin : gTail
      assign w_leave[g] = w_go & w_valid[g] & out_ready;
    end else begin : gInner
      assign w_leave[g] = w_go & w_valid[g] & w_ready[g+1];
    end

    assign w_clear[g] = flush | w_leave[g];

    pipeline_stage #(
      .N           (N),
      .RESET_VALUE (RESET_VALUE)
    ) uStage (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[g]),
      .i_clear (w_clear[g]),
      .i_data  (w_stageIn[g]),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g])
    );
  end

  assign in_ready  = w_go & w_ready[0];
  assign out_valid = w_go & w_valid[STAGES-1];
  assign out_data  = w_data[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(w_valid[i]);
    end
  end

`ifdef PIPELINE_REGISTER_COUNT_EN
  logic [XFER_COUNT_W-1:0] r_xferCount;

  // Counts completed output handshakes; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xferCount <= '0;
    end else if (out_valid & out_ready) begin
      r_xferCount <= r_xferCount + XFER_COUNT_W'(1);
    end
  end

  assign xfer_count = r_xferCount;
`else
  // This build carries no output-transfer counter.
`endif

endmodule

// File: tb/tb_pipeline_register.sv
// Directed bench for pipeline_register (N=8, STAGES=3, RESET_VALUE=8'h5A).
// Inputs change #1 after each rising edge; outputs are checked before the next edge.
module tb_pipeline_register;

  localparam int N      = 8;
  localparam int STAGES = 3;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef PIPELINE_REGISTER_COUNT_EN
  logic [31:0]  xfer_count;
`endif

  int assertCount = 0;
  int failCount   = 0;

  pipeline_register #(
    .N           (N),
    .STAGES      (STAGES),
    .RESET_VALUE (8'h5A)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPELINE_REGISTER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic advanceClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [N-1:0] data, input logic ready);
    in_valid  = valid;
    in_data   = data;
    out_ready = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset
    advanceClock();
    advanceClock();
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("rst_occupancy", {30'd0, occupancy}, 32'd0);
    checkOutput("rst_out_data",  {24'd0, out_data},  32'h5A);
`ifdef PIPELINE_REGISTER_COUNT_EN
    checkOutput("rst_xfer_count", xfer_count, 32'd0);
`endif

    // Latency: item visible only after the third edge
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("lat_in_ready", {31'd0, in_ready}, 32'd1);
    advanceClock();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("lat_c1_out_valid", {31'd0, out_valid}, 32'd0);
    advanceClock();
    checkOutput("lat_c2_out_valid", {31'd0, out_valid}, 32'd0);
    advanceClock();
    checkOutput("lat_c3_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("lat_c3_out_data",  {24'd0, out_data},  32'hA5);
    advanceClock();
    checkOutput("lat_drained_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("lat_drained_occ",   {30'd0, occupancy}, 32'd0);

    // Fill with out_ready low: only three items fit
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, N'(k), 1'b0);
      checkOutput("fill_in_ready", {31'd0, in_ready}, 32'd1);
      advanceClock();
    end
    applyStimulus(1'b1, 8'h04, 1'b0);
    checkOutput("full_in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("full_occupancy", {30'd0, occupancy}, 32'd3);
    advanceClock();
    checkOutput("stall_occupancy", {30'd0, occupancy}, 32'd3);
    checkOutput("stall_out_data",  {24'd0, out_data},  32'h01);

    // Drain while 04 and 05 are still offered
    for (int c = 0; c < 5; c++) begin
      applyStimulus(c < 2, N'(4 + c), 1'b1);
      checkOutput("drain_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("drain_out_data",  {24'd0, out_data},  32'(1 + c));
      if (c < 2) checkOutput("drain_in_ready", {31'd0, in_ready}, 32'd1);
      advanceClock();
    end
    checkOutput("drained_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drained_occ",       {30'd0, occupancy}, 32'd0);
`ifdef PIPELINE_REGISTER_COUNT_EN
    checkOutput("drain_xfer_count", xfer_count, 32'd6);
`endif

    // Bubble collapse
    applyStimulus(1'b1, 8'h11, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 8'h00, 1'b0);
    advanceClock();
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("bubble_in_ready", {31'd0, in_ready}, 32'd1);
    advanceClock();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("bubble_occupancy", {30'd0, occupancy}, 32'd2);
    checkOutput("bubble_in_ready2", {31'd0, in_ready},  32'd1);
    checkOutput("bubble_out_data",  {24'd0, out_data},  32'h11);
    applyStimulus(1'b1, 8'h33, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("bubble_full_occ",   {30'd0, occupancy}, 32'd3);
    checkOutput("bubble_full_ready", {31'd0, in_ready},  32'd0);

    // Simultaneous push and pop on a full pipe
    applyStimulus(1'b1, 8'h44, 1'b1);
    checkOutput("simul_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("simul_out_data", {24'd0, out_data}, 32'h11);
    advanceClock();
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("simul_occ1",      {30'd0, occupancy}, 32'd3);
    checkOutput("simul_out_data1", {24'd0, out_data},  32'h22);
    advanceClock();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("simul_occ2",      {30'd0, occupancy}, 32'd3);
    checkOutput("simul_out_data2", {24'd0, out_data},  32'h33);

    // Global enable low freezes everything
    ena = 1'b0;
    applyStimulus(1'b1, 8'h66, 1'b1);
    checkOutput("ena0_in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("ena0_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ena0_occupancy", {30'd0, occupancy}, 32'd3);
    advanceClock();
    checkOutput("ena0_occ_after",  {30'd0, occupancy}, 32'd3);
    checkOutput("ena0_data_after", {24'd0, out_data},  32'h33);

    // Flush squashes items but keeps data registers
    ena = 1'b1;
    flush = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("flush_in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    advanceClock();
    flush = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("flush_occupancy", {30'd0, occupancy}, 32'd0);
    checkOutput("flush_out_valid2", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_out_data",  {24'd0, out_data},  32'h33);
`ifdef PIPELINE_REGISTER_COUNT_EN
    checkOutput("flush_xfer_count", xfer_count, 32'd8);
`endif

    // Reset mid-stream discards held items
    applyStimulus(1'b1, 8'h88, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("mid_occ_before", {30'd0, occupancy}, 32'd1);
    rst = 1'b1;
    advanceClock();
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_occ",      {30'd0, occupancy}, 32'd0);
    checkOutput("mid_rst_out_data", {24'd0, out_data},  32'h5A);
    checkOutput("mid_rst_in_ready", {31'd0, in_ready},  32'd1);
`ifdef PIPELINE_REGISTER_COUNT_EN
    checkOutput("mid_rst_xfer_count", xfer_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
